// File: rtl/dm_responder_pkg.sv
// Shared memory-access encodings and responder states.
// Used by the decoder, memory stage and data-memory responder.
package dm_responder_pkg;

  localparam int MEM_TYPE_LEN = 2;

  localparam logic [MEM_TYPE_LEN-1:0] MEM_BYTE = 2'd0;
  localparam logic [MEM_TYPE_LEN-1:0] MEM_HALF = 2'd1;
  localparam logic [MEM_TYPE_LEN-1:0] MEM_WORD = 2'd2;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_t;

endpackage

// File: rtl/dm_store_align.sv
// Store lane alignment: byte enables, replicated lane data, misalign flag.
// Purely combinational; also reused by the memory-stage alignment check.
module dm_store_align
  import dm_responder_pkg::*;
(
  input  logic [MEM_TYPE_LEN-1:0] mem_type,
  input  logic [1:0]              addr_lo,
  input  logic [31:0]             wdata,
  output logic [3:0]              be,
  output logic [31:0]             lane_data,
  output logic                    misaligned
);

  // Decode access size into lanes and alignment.
  always_comb begin
    be         = 4'b0000;
    lane_data  = wdata;
    misaligned = 1'b0;
    unique case (1'b1)
      (mem_type == MEM_WORD): begin
        be         = 4'b1111;
        lane_data  = wdata;
        misaligned = (addr_lo != 2'b00);
      end
      (mem_type == MEM_HALF): begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      (mem_type == MEM_BYTE): begin
        be         = 4'b0001 << addr_lo;
        lane_data  = {4{wdata[7:0]}};
      end
      default: begin
        be         = 4'b0000;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, LATENCY wait states.
// Define DM_WRITE_LOG_EN to print a trace line for every good store.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [MEM_TYPE_LEN-1:0] req_type,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  input  logic [31:0]             req_pc,
  output logic                    resp_valid,
  output logic [31:0]             resp_rdata,
  output logic                    resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int HI_SH = IDX_W + 2;

  dm_state_t state;
  dm_state_t state_nx;

  logic [3:0]              cnt;
  logic                    l_write;
  logic [MEM_TYPE_LEN-1:0] l_type;
  logic [31:0]             l_addr;
  logic [31:0]             l_wdata;
  logic [31:0]             l_pc;

  logic [31:0] mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [31:0]      hi_bits;
  logic             oor;
  logic [3:0]       be;
  logic [31:0]      lane_data;
  logic             misaligned;
  logic             err;
  logic [31:0]      rd_word;
  logic [31:0]      merged;
  logic             accept;
  logic             access;

  dm_store_align u_align (
    .mem_type   (l_type),
    .addr_lo    (l_addr[1:0]),
    .wdata      (l_wdata),
    .be         (be),
    .lane_data  (lane_data),
    .misaligned (misaligned)
  );

  assign idx     = l_addr[IDX_W+1:2];
  assign hi_bits = l_addr >> HI_SH;
  assign oor     = |hi_bits;
  assign err     = oor | misaligned;
  assign rd_word = mem[idx];
  assign accept  = (state == DM_IDLE) && req_valid;
  assign access  = (state == DM_WAIT) && (cnt == 4'd0);

  // Merge enabled store lanes over the current word.
  always_comb begin
    merged = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = lane_data[8*b +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= DM_IDLE;
    else       state <= state_nx;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      DM_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = DM_WAIT;
      end
      DM_WAIT: begin
        if (cnt == 4'd0) state_nx = DM_RESP;
      end
      DM_RESP: begin
        resp_valid = 1'b1;
        state_nx   = DM_IDLE;
      end
      default: state_nx = DM_IDLE;
    endcase
  end

  // Request capture and wait-state counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 4'd0;
      l_write <= 1'b0;
      l_type  <= MEM_WORD;
      l_addr  <= 32'd0;
      l_wdata <= 32'd0;
      l_pc    <= 32'd0;
    end else if (accept) begin
      cnt     <= 4'(LATENCY);
      l_write <= req_write;
      l_type  <= req_type;
      l_addr  <= req_addr;
      l_wdata <= req_wdata;
      l_pc    <= req_pc;
    end else if (state == DM_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response data, held until the next access.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (access) begin
      resp_err   <= err;
      resp_rdata <= (err || l_write) ? 32'd0 : rd_word;
    end
  end

  // Array: cleared on reset, written on a good store access.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (access && l_write && !err) begin
      mem[idx] <= merged;
`ifdef DM_WRITE_LOG_EN
      $display("%d@%h: *%h <= %h", $time, l_pc,
               l_addr & ~32'd3, merged);
`else
`endif
    end
  end

endmodule
